// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: grants one requester per two-cycle round and drives a
// one-hot enable plus a shared data bus into a bank of 8-bit registers.
`default_nettype none

module reg_write_arbiter #(
    parameter int NREQ = 3,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [NREG-1:0]   reg_enable,
    output logic [7:0]        reg_data,
    output logic [1:0]        grant_id,
    output logic              busy,
    output logic [0:0]        state_dbg
);

    // Handshake: a requester raises req with addr/data and holds all three stable
    // until it sees its one-cycle ack; req still high after the ack cycle counts
    // as a fresh request that competes at lowest priority.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;
    localparam logic [1:0] LAST_RESET = 2'(NREQ - 1);

    logic [0:0]    state;
    logic [1:0]    last_grant;
    logic          win_found;
    logic [1:0]    win_id;
    logic [1:0]    cand;
    logic [AW-1:0] win_addr;
    logic [7:0]    win_data;

    // Scan upward from the requester after the previous winner, wrapping mod NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(last_grant) + i) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_addr = req_addr[int'(win_id)*AW +: AW];
        win_data = req_data[int'(win_id)*8 +: 8];
    end

    // All outputs are registered; the IDLE edge that picks a winner loads the
    // write that is presented to the bank during the following WRITE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_RESET;
            reg_enable <= '0;
            reg_data   <= 8'h00;
            ack        <= '0;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state      <= WRITE;
                        last_grant <= win_id;
                        reg_enable <= NREG'(1) << win_addr;
                        reg_data   <= win_data;
                        ack        <= NREQ'(1) << win_id;
                        grant_id   <= win_id;
                        busy       <= 1'b1;
                    end
                end
                WRITE: begin
                    // reg_data is left holding; it is ignored while enables are low.
                    state      <= IDLE;
                    reg_enable <= '0;
                    ack        <= '0;
                    grant_id   <= 2'd0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    reg_enable <= '0;
                    ack        <= '0;
                    grant_id   <= 2'd0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grants and bank contents.
`timescale 1ns/1ps

module tb_reg_write_arbiter;
    localparam int NREQ = 3;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREG-1:0]   reg_enable;
    logic [7:0]        reg_data;
    logic [1:0]        grant_id;
    logic              busy;
    logic [0:0]        state_dbg;

    logic [7:0] bank [NREG];
    logic       bank_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .reg_enable(reg_enable), .reg_data(reg_data), .grant_id(grant_id),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Stand-in for the register bank fed by the arbiter.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bank_clr) bank[i] <= 8'h00;
            else if (reg_enable[i]) bank[i] <= reg_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [7:0] d);
        req[k] = 1'b1;
        req_addr[k*AW +: AW] = a;
        req_data[k*8 +: 8] = d;
    endtask

    task automatic clear_req(input int k);
        req[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bank_clr = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
        tick();
        tick();
        reset = 1'b0;
        bank_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bank_clr = 1'b1;
        req = '1;
        req_addr = '0;
        req_data = '1;
        tick();
        tick();
        n_checks++;
        if (reg_enable !== 4'b0000 || reg_data !== 8'h00 || ack !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b data=%h ack=%b expected en=0000 data=00 ack=000",
                     reg_enable, reg_data, ack);
        end
        n_checks++;
        if (grant_id !== 2'd0 || busy !== 1'b0 || state_dbg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gid=%0d busy=%b state=%b expected gid=0 busy=0 state=0",
                     grant_id, busy, state_dbg);
        end
        req = '0;
        reset = 1'b0;
        bank_clr = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(1, 2'd2, 8'hA5);
        tick();
        n_checks++;
        if (reg_enable !== 4'b0100 || reg_data !== 8'hA5 || ack !== 3'b010) begin
            n_fail++;
            $display("FAIL single_write: got en=%b data=%h ack=%b expected en=0100 data=a5 ack=010",
                     reg_enable, reg_data, ack);
        end
        n_checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || state_dbg !== 1'b1) begin
            n_fail++;
            $display("FAIL single_status: got busy=%b gid=%0d state=%b expected busy=1 gid=1 state=1",
                     busy, grant_id, state_dbg);
        end
        clear_req(1);
        tick();
        n_checks++;
        if (bank[2] !== 8'hA5 || ack !== 3'b000 || reg_enable !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_capture: got bank2=%h ack=%b en=%b expected bank2=a5 ack=000 en=0000",
                     bank[2], ack, reg_enable);
        end
    endtask

    task automatic test_release_order();
        int grants[$];
        int when[$];
        int cyc;
        int g;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, AW'(k), 8'h10 + 8'(k));
        cyc = 0;
        while (grants.size() < 3 && cyc < 20) begin
            tick();
            cyc++;
            n_checks++;
            if ($countones(ack) > 1) begin
                n_fail++;
                $display("FAIL release_onehot: got ack=%b expected at most one bit", ack);
            end else if (ack != '0) begin
                g = 0;
                for (int k = 0; k < NREQ; k++) if (ack[k]) g = k;
                grants.push_back(g);
                when.push_back(cyc);
                clear_req(g);
            end
        end
        n_checks++;
        if (grants.size() != 3) begin
            n_fail++;
            $display("FAIL release_timeout: got %0d grants expected 3 within 20 cycles", grants.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (grants[i] != i || when[i] - when[0] != 2 * i) begin
                    n_fail++;
                    $display("FAIL release_order[%0d]: got id=%0d gap=%0d expected id=%0d gap=%0d",
                             i, grants[i], when[i] - when[0], i, 2 * i);
                end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_continuous();
        int grants[$];
        int g;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, AW'(k), 8'h40 + 8'(k));
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ack != '0) begin
                g = 0;
                for (int k = 0; k < NREQ; k++) if (ack[k]) g = k;
                grants.push_back(g);
            end
        end
        n_checks++;
        if (grants.size() != 6) begin
            n_fail++;
            $display("FAIL continuous_count: got %0d grants expected 6", grants.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (grants[i] != i % NREQ) begin
                    n_fail++;
                    $display("FAIL continuous_order[%0d]: got id=%0d expected id=%0d", i, grants[i], i % NREQ);
                end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_same_target();
        do_reset();
        set_req(0, 2'd3, 8'h11);
        set_req(2, 2'd3, 8'h22);
        tick();
        n_checks++;
        if (ack !== 3'b001) begin
            n_fail++;
            $display("FAIL same_first_ack: got ack=%b expected 001", ack);
        end
        clear_req(0);
        tick();
        n_checks++;
        if (bank[3] !== 8'h11) begin
            n_fail++;
            $display("FAIL same_first_data: got bank3=%h expected 11", bank[3]);
        end
        tick();
        n_checks++;
        if (ack !== 3'b100) begin
            n_fail++;
            $display("FAIL same_second_ack: got ack=%b expected 100", ack);
        end
        clear_req(2);
        tick();
        n_checks++;
        if (bank[3] !== 8'h22) begin
            n_fail++;
            $display("FAIL same_final: got bank3=%h expected 22", bank[3]);
        end
    endtask

    task automatic test_input_change();
        do_reset();
        set_req(0, 2'd1, 8'h3C);
        tick();
        req_addr[0 +: AW] = 2'd0;
        req_data[0 +: 8] = 8'hFF;
        clear_req(0);
        n_checks++;
        if (reg_enable !== 4'b0010 || reg_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL change_latched: got en=%b data=%h expected en=0010 data=3c", reg_enable, reg_data);
        end
        tick();
        tick();
        n_checks++;
        if (bank[1] !== 8'h3C || bank[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL change_bank: got bank1=%h bank0=%h expected bank1=3c bank0=00", bank[1], bank[0]);
        end
    endtask

    task automatic test_reset_during_write();
        do_reset();
        set_req(1, 2'd2, 8'h5A);
        tick();
        reset = 1'b1;
        clear_req(1);
        n_checks++;
        if (reg_enable !== 4'b0100 || reg_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_write_drive: got en=%b data=%h expected en=0100 data=5a", reg_enable, reg_data);
        end
        tick();
        n_checks++;
        if (bank[2] !== 8'h5A) begin
            n_fail++;
            $display("FAIL rst_write_capture: got bank2=%h expected 5a", bank[2]);
        end
        n_checks++;
        if (reg_enable !== 4'b0000 || reg_data !== 8'h00 || ack !== 3'b000 || grant_id !== 2'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_write_outputs: got en=%b data=%h ack=%b gid=%0d busy=%b expected all zero",
                     reg_enable, reg_data, ack, grant_id, busy);
        end
        reset = 1'b0;
        set_req(0, 2'd0, 8'h01);
        set_req(2, 2'd1, 8'h02);
        tick();
        n_checks++;
        if (ack !== 3'b001 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_write_priority: got ack=%b gid=%0d expected ack=001 gid=0", ack, grant_id);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [NREG-1:0] m_en, n_en;
        logic [NREQ-1:0] m_ack, n_ack;
        logic [7:0]      m_data, n_data;
        logic [1:0]      m_gid, n_gid;
        logic            m_busy, n_busy;
        logic [AW-1:0]   m_addr, n_addr;
        logic [7:0]      exp_bank [NREG];
        int              m_last;
        int              w;
        int              c;
        logic            bank_ok;
        do_reset();
        m_en = '0; m_ack = '0; m_data = 8'h00; m_gid = 2'd0; m_busy = 1'b0; m_addr = '0;
        m_last = NREQ - 1;
        for (int i = 0; i < NREG; i++) exp_bank[i] = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 49) == 0);
            // Whatever is enabled during this cycle lands in the bank at the coming edge.
            if (m_en != '0) exp_bank[m_addr] = m_data;
            n_en = '0; n_ack = '0; n_gid = 2'd0; n_busy = 1'b0; n_data = m_data; n_addr = m_addr;
            if (reset) begin
                n_data = 8'h00;
                m_last = NREQ - 1;
            end else if (!m_busy && req != '0) begin
                w = -1;
                for (int off = 1; off <= NREQ; off++) begin
                    c = (m_last + off) % NREQ;
                    if (w < 0 && req[c]) w = c;
                end
                n_addr = req_addr[w*AW +: AW];
                n_data = req_data[w*8 +: 8];
                n_en   = NREG'(1) << n_addr;
                n_ack  = NREQ'(1) << w;
                n_gid  = 2'(w);
                n_busy = 1'b1;
                m_last = w;
            end
            tick();
            n_checks++;
            if (ack !== n_ack || grant_id !== n_gid || busy !== n_busy) begin
                n_fail++;
                $display("FAIL rand_grant@%0d: got ack=%b gid=%0d busy=%b expected ack=%b gid=%0d busy=%b",
                         cyc, ack, grant_id, busy, n_ack, n_gid, n_busy);
            end
            n_checks++;
            if (reg_enable !== n_en || (n_en != '0 && reg_data !== n_data) || (reset && reg_data !== 8'h00)) begin
                n_fail++;
                $display("FAIL rand_write@%0d: got en=%b data=%h expected en=%b data=%h",
                         cyc, reg_enable, reg_data, n_en, n_data);
            end
            bank_ok = 1'b1;
            for (int i = 0; i < NREG; i++) if (bank[i] !== exp_bank[i]) bank_ok = 1'b0;
            n_checks++;
            if (!bank_ok) begin
                n_fail++;
                $display("FAIL rand_bank@%0d: got %h %h %h %h expected %h %h %h %h", cyc,
                         bank[0], bank[1], bank[2], bank[3],
                         exp_bank[0], exp_bank[1], exp_bank[2], exp_bank[3]);
            end
            m_en = n_en; m_ack = n_ack; m_data = n_data; m_gid = n_gid; m_busy = n_busy; m_addr = n_addr;
            for (int k = 0; k < NREQ; k++) begin
                if (ack[k]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(k, AW'($urandom_range(0, NREG - 1)), 8'($urandom_range(0, 255)));
                    else
                        clear_req(k);
                end else if (!req[k] && $urandom_range(0, 2) == 0) begin
                    set_req(k, AW'($urandom_range(0, NREG - 1)), 8'($urandom_range(0, 255)));
                end
            end
        end
        reset = 1'b0;
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bank_clr = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single_write();
        test_release_order();
        test_continuous();
        test_same_target();
        test_input_change();
        test_reset_during_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
